// File: rtl/multi_chan_gated_counter_pkg.sv
// -----------------------------------------------------------------------------
// multi_chan_gated_counter_pkg
// Shared types and helpers for the multi-channel clock-gated counter.
//   chan_state_e     : per-channel idle FSM state (ACTIVE / GATED)
//   MODE_WRAP/SAT    : overflow mode selectors for the SAT parameter
//   idle_cnt_width() : width of the per-channel idle counter
// -----------------------------------------------------------------------------
package multi_chan_gated_counter_pkg;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    typedef enum logic {
        ACTIVE = 1'b0,
        GATED  = 1'b1
    } chan_state_e;

    // Idle counter must hold values 0..IDLE_CYC.
    function automatic int unsigned idle_cnt_width(input int unsigned idle_cyc);
        return (idle_cyc < 1) ? 1 : $clog2(idle_cyc + 1);
    endfunction

endpackage

// File: rtl/gated_counter_chan.sv
// -----------------------------------------------------------------------------
// gated_counter_chan
// One channel: accumulating counter (wrap or saturate), terminal-count pulse,
// and idle detector driving a clock-gate enable.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   increase_i   : per-cycle increment
//   clr_i        : synchronous clear (wins over increase_i)
//   count_o      : registered count
//   tc_o         : registered one-cycle terminal-count pulse
//   gate_en_o    : clock-gate enable (combinational on act)
//   active_o     : registered state is ACTIVE
// -----------------------------------------------------------------------------
module gated_counter_chan
    import multi_chan_gated_counter_pkg::*;
#(
    parameter int unsigned CW       = 8,
    parameter int unsigned IW       = 3,
    parameter int unsigned IDLE_CYC = 4,
    parameter int unsigned SAT      = MODE_WRAP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] increase_i,
    input  logic          clr_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o,
    output logic          gate_en_o,
    output logic          active_o
);

    localparam int unsigned   ICW       = idle_cnt_width(IDLE_CYC);
    localparam int unsigned   SW        = CW + 1;
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_CYC - 1);

    logic           act;
    logic [CW:0]    sum;
    logic [CW-1:0]  count_q, count_d;
    logic           tc_q, tc_d;
    chan_state_e    state_q;
    logic [ICW-1:0] idle_q;

    assign act = (increase_i != '0) | clr_i;
    assign sum = {1'b0, count_q} + SW'(increase_i);

    // Next count / terminal-count decode
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (increase_i != '0) begin
            if (SAT == MODE_SAT) begin
                if (sum[CW] || (sum[CW-1:0] == CNT_MAX)) begin
                    count_d = CNT_MAX;
                    // pulse only on the edge into max, not while pinned there
                    tc_d    = (count_q != CNT_MAX);
                end else begin
                    count_d = sum[CW-1:0];
                end
            end else begin
                count_d = sum[CW-1:0];
                tc_d    = sum[CW];
            end
        end
    end

    // Count register loads only on act (gated clock domain); tc clears every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            tc_q <= tc_d;
            if (act) begin
                count_q <= count_d;
            end
        end
    end

    // Idle FSM: gate after IDLE_CYC consecutive idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACTIVE;
            idle_q  <= '0;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (act) begin
                        idle_q <= '0;
                    end else begin
                        idle_q <= idle_q + ICW'(1);
                        if (idle_q == IDLE_LAST) begin
                            state_q <= GATED;
                        end
                    end
                end
                GATED: begin
                    if (act) begin
                        state_q <= ACTIVE;
                        idle_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ACTIVE;
                    idle_q  <= '0;
                end
            endcase
        end
    end

    assign count_o   = count_q;
    assign tc_o      = tc_q;
    // act bypass keeps the waking increment from being lost
    assign gate_en_o = (state_q != GATED) | act;
    assign active_o  = (state_q == ACTIVE);

endmodule

// File: rtl/multi_chan_gated_counter.sv
// -----------------------------------------------------------------------------
// multi_chan_gated_counter
// CH independent clock-gated counters; slices buses and reduces busy.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   increase_i  : CH*IW, channel i at [i*IW +: IW]
//   clr_i       : CH per-channel synchronous clear
//   count_o     : CH*CW, channel i at [i*CW +: CW]
//   tc_o        : CH one-cycle terminal-count pulses
//   gate_en_o   : CH per-channel clock-gate enables
//   busy_o      : any channel in ACTIVE state
// -----------------------------------------------------------------------------
module multi_chan_gated_counter
    import multi_chan_gated_counter_pkg::*;
#(
    parameter int unsigned CH       = 4,
    parameter int unsigned CW       = 8,
    parameter int unsigned IW       = 3,
    parameter int unsigned IDLE_CYC = 4,
    parameter int unsigned SAT      = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*IW-1:0] increase_i,
    input  logic [CH-1:0]    clr_i,
    output logic [CH*CW-1:0] count_o,
    output logic [CH-1:0]    tc_o,
    output logic [CH-1:0]    gate_en_o,
    output logic             busy_o
);

    if ((IDLE_CYC < 1) || (IW > CW)) begin : gen_param_err
        $error("multi_chan_gated_counter: need IDLE_CYC >= 1 and IW <= CW");
    end

    logic [CH-1:0] active;

    for (genvar i = 0; i < CH; i++) begin : gen_ch
        gated_counter_chan #(
            .CW       (CW),
            .IW       (IW),
            .IDLE_CYC (IDLE_CYC),
            .SAT      (SAT)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .increase_i (increase_i[i*IW +: IW]),
            .clr_i      (clr_i[i]),
            .count_o    (count_o[i*CW +: CW]),
            .tc_o       (tc_o[i]),
            .gate_en_o  (gate_en_o[i]),
            .active_o   (active[i])
        );
    end

    assign busy_o = |active;

endmodule
